// File: rtl/jackpot_pkg.sv
// -----------------------------------------------------------------------------
// jackpot_pkg
// Shared types and constants for the jackpot reaction game.
//   jp_state_t    : game state (RUN = light walking, WIN = blink sequence)
//   jp_dir_t      : ping-pong walk direction (DIR_DOWN = toward LSB)
//   JP_ARM_CYCLES : cycles after reset release before switch edges count
//   jp_lvl_w()    : width of the level counter for a given number of levels
// -----------------------------------------------------------------------------
package jackpot_pkg;

    typedef enum logic {
        RUN = 1'b0,
        WIN = 1'b1
    } jp_state_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } jp_dir_t;

    localparam int JP_ARM_CYCLES = 3;

    // A single level still needs a one-bit register to hold the value 0.
    function automatic int jp_lvl_w(input int levels);
        return (levels > 1) ? $clog2(levels) : 1;
    endfunction

endpackage

// File: rtl/jackpot_tick_gen.sv
// -----------------------------------------------------------------------------
// jackpot_tick_gen
// Step-rate divider. Produces a one-cycle step pulse every
// max(DIV_BASE >> level, 1) clock cycles.
// Ports:
//   i_clk    in   clock, rising edge
//   i_rst_n  in   asynchronous active-low reset
//   i_level  in   current speed level (selects the period)
//   i_clear  in   restart the period from zero on the next cycle
//   o_step   out  step pulse, high in the last cycle of each period
// -----------------------------------------------------------------------------
module jackpot_tick_gen #(
    parameter int DIV_BASE = 62_500_000,
    parameter int LEVELS   = 4,
    parameter int LVL_W    = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [LVL_W-1:0] i_level,
    input  logic             i_clear,
    output logic             o_step
);
    import jackpot_pkg::*;

    localparam int CNT_W = $clog2(DIV_BASE + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      w_period_raw;
    logic [31:0]      w_period;

    // Period for the current level; a shift down to zero is held at one so
    // the fastest levels step every cycle instead of never.
    always_comb begin
        w_period_raw = 32'(DIV_BASE) >> i_level;
        if (w_period_raw == 32'd0) begin
            w_period = 32'd1;
        end else begin
            w_period = w_period_raw;
        end
    end

    // '>=' keeps the divider live even if the counter ever sits beyond the
    // current period.
    assign o_step = (32'(r_cnt) >= (w_period - 32'd1));

    // Step counter: wraps on each step, restarts on clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clear || o_step) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/jackpot_game.sv
// -----------------------------------------------------------------------------
// jackpot_game
// A one-hot light walks across LEDS (rotate or ping-pong). A switch rising
// edge landing on the lit LED scores a hit, plays a blink sequence in WIN,
// and raises the speed level for the next round.
// Ports:
//   CLOCK     in   board clock, rising edge
//   RESET     in   asynchronous active-low reset
//   SWITCHES  in   [N_LEDS]  asynchronous slide switches
//   MODE      in   0 = rotate, 1 = ping-pong (sampled at each step)
//   LEDS      out  [N_LEDS]  light pattern
//   SCORE     out  [SCORE_W] saturating hit count
//   LEVEL     out  current speed level
//   WIN       out  high while the blink sequence plays
// Build option:
//   JACKPOT_MISS_PENALTY_EN  when defined, a switch edge in RUN that misses
//                            the lit LED drops LEVEL to 0 and SCORE by one.
// -----------------------------------------------------------------------------
module jackpot_game #(
    parameter int N_LEDS    = 4,
    parameter int DIV_BASE  = 62_500_000,
    parameter int LEVELS    = 4,
    parameter int WIN_STEPS = 6,
    parameter int SCORE_W   = 8
) (
    input  logic                                         CLOCK,
    input  logic                                         RESET,
    input  logic [N_LEDS-1:0]                            SWITCHES,
    input  logic                                         MODE,
    output logic [N_LEDS-1:0]                            LEDS,
    output logic [SCORE_W-1:0]                           SCORE,
    output logic [((LEVELS > 1) ? $clog2(LEVELS) : 1)-1:0] LEVEL,
    output logic                                         WIN
);
    import jackpot_pkg::*;

    localparam int LVL_W   = jp_lvl_w(LEVELS);
    localparam int ARM_W   = $clog2(JP_ARM_CYCLES + 1);
    localparam int BLINK_W = $clog2(WIN_STEPS + 1);

    localparam logic [N_LEDS-1:0]  LEDS_MSB  = {1'b1, {(N_LEDS-1){1'b0}}};
    localparam logic [N_LEDS-1:0]  LEDS_ALL  = {N_LEDS{1'b1}};
    localparam logic [N_LEDS-1:0]  LEDS_NONE = {N_LEDS{1'b0}};
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [LVL_W-1:0]   LEVEL_MAX = LVL_W'(LEVELS - 1);

    // Switch input path
    logic [N_LEDS-1:0] r_meta;
    logic [N_LEDS-1:0] r_sync;
    logic [N_LEDS-1:0] r_sync_d;
    logic [N_LEDS-1:0] r_edge;
    logic [ARM_W-1:0]  r_arm;
    logic              w_armed;

    // Game state
    jp_state_t         r_state;
    jp_state_t         w_state_nxt;
    jp_dir_t           r_dir;
    jp_dir_t           w_dir_nxt;
    logic [N_LEDS-1:0] r_leds;
    logic [N_LEDS-1:0] w_leds_nxt;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [LVL_W-1:0]  r_level;
    logic [LVL_W-1:0]  w_level_nxt;
    logic [BLINK_W-1:0] r_blink;
    logic [BLINK_W-1:0] w_blink_nxt;
    logic              w_clear;
    logic              w_step;
    logic              w_hit;
    logic              w_blink_last;

    assign w_armed      = (r_arm == ARM_W'(JP_ARM_CYCLES));
    assign w_hit        = (r_state == jackpot_pkg::RUN) && (|(r_edge & r_leds));
    assign w_blink_last = (r_blink == BLINK_W'(WIN_STEPS - 1));

`ifdef JACKPOT_MISS_PENALTY_EN
    logic w_miss;
    assign w_miss = (r_state == jackpot_pkg::RUN) && (|r_edge) && !w_hit;
`endif

    jackpot_tick_gen #(
        .DIV_BASE (DIV_BASE),
        .LEVELS   (LEVELS),
        .LVL_W    (LVL_W)
    ) u_tick (
        .i_clk   (CLOCK),
        .i_rst_n (RESET),
        .i_level (r_level),
        .i_clear (w_clear),
        .o_step  (w_step)
    );

    // Two-stage synchroniser, rising-edge register and post-reset arm delay.
    // Edges are suppressed until armed so a switch held through reset,
    // which looks like a 0->1 change as the synchroniser fills, never scores.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_meta   <= LEDS_NONE;
            r_sync   <= LEDS_NONE;
            r_sync_d <= LEDS_NONE;
            r_edge   <= LEDS_NONE;
            r_arm    <= {ARM_W{1'b0}};
        end else begin
            r_meta   <= SWITCHES;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_edge   <= w_armed ? (r_sync & ~r_sync_d) : LEDS_NONE;
            if (!w_armed) begin
                r_arm <= r_arm + ARM_W'(1);
            end else begin
                r_arm <= r_arm;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= jackpot_pkg::RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            jackpot_pkg::RUN: begin
                if (w_hit) begin
                    w_state_nxt = jackpot_pkg::WIN;
                end else begin
                    w_state_nxt = jackpot_pkg::RUN;
                end
            end
            jackpot_pkg::WIN: begin
                if (w_step && w_blink_last) begin
                    w_state_nxt = jackpot_pkg::RUN;
                end else begin
                    w_state_nxt = jackpot_pkg::WIN;
                end
            end
            default: w_state_nxt = jackpot_pkg::RUN;
        endcase
    end

    // Next values for the light pattern, direction, score, level and blink
    // count. A hit is checked against the pre-step pattern and takes priority
    // over a coincident step, which is then dropped.
    always_comb begin
        w_leds_nxt  = r_leds;
        w_dir_nxt   = r_dir;
        w_score_nxt = r_score;
        w_level_nxt = r_level;
        w_blink_nxt = r_blink;
        w_clear     = 1'b0;
        case (r_state)
            jackpot_pkg::RUN: begin
                if (w_hit) begin
                    w_leds_nxt  = LEDS_ALL;
                    w_score_nxt = (r_score != SCORE_MAX) ? r_score + SCORE_W'(1) : r_score;
                    w_level_nxt = (r_level != LEVEL_MAX) ? r_level + LVL_W'(1) : r_level;
                    w_blink_nxt = {BLINK_W{1'b0}};
                    w_clear     = 1'b1;
`ifdef JACKPOT_MISS_PENALTY_EN
                end else if (w_miss) begin
                    w_level_nxt = {LVL_W{1'b0}};
                    w_score_nxt = (r_score != {SCORE_W{1'b0}}) ? r_score - SCORE_W'(1) : r_score;
                    w_clear     = 1'b1;
`endif
                end else if (w_step) begin
                    if (!MODE) begin
                        w_leds_nxt = {r_leds[0], r_leds[N_LEDS-1:1]};
                    end else if (r_dir == DIR_DOWN) begin
                        // Bounce off bit 0: the end LED stays lit for one step.
                        if (r_leds[0]) begin
                            w_dir_nxt  = DIR_UP;
                            w_leds_nxt = {r_leds[N_LEDS-2:0], 1'b0};
                        end else begin
                            w_leds_nxt = {1'b0, r_leds[N_LEDS-1:1]};
                        end
                    end else begin
                        if (r_leds[N_LEDS-1]) begin
                            w_dir_nxt  = DIR_DOWN;
                            w_leds_nxt = {1'b0, r_leds[N_LEDS-1:1]};
                        end else begin
                            w_leds_nxt = {r_leds[N_LEDS-2:0], 1'b0};
                        end
                    end
                end else begin
                    w_leds_nxt = r_leds;
                end
            end
            jackpot_pkg::WIN: begin
                if (w_step) begin
                    if (w_blink_last) begin
                        w_leds_nxt  = LEDS_MSB;
                        w_dir_nxt   = DIR_DOWN;
                        w_blink_nxt = {BLINK_W{1'b0}};
                        w_clear     = 1'b1;
                    end else begin
                        w_leds_nxt  = ~r_leds;
                        w_blink_nxt = r_blink + BLINK_W'(1);
                    end
                end else begin
                    w_leds_nxt = r_leds;
                end
            end
            default: begin
                w_leds_nxt  = LEDS_MSB;
                w_dir_nxt   = DIR_DOWN;
                w_blink_nxt = {BLINK_W{1'b0}};
                w_clear     = 1'b1;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_leds  <= LEDS_MSB;
            r_dir   <= DIR_DOWN;
            r_score <= {SCORE_W{1'b0}};
            r_level <= {LVL_W{1'b0}};
            r_blink <= {BLINK_W{1'b0}};
        end else begin
            r_leds  <= w_leds_nxt;
            r_dir   <= w_dir_nxt;
            r_score <= w_score_nxt;
            r_level <= w_level_nxt;
            r_blink <= w_blink_nxt;
        end
    end

    // FSM outputs, all taken straight from registers.
    always_comb begin
        LEDS  = r_leds;
        SCORE = r_score;
        LEVEL = r_level;
        WIN   = (r_state == jackpot_pkg::WIN);
    end

endmodule

// File: tb/tb_jackpot_game.sv
// -----------------------------------------------------------------------------
// tb_jackpot_game
// Directed bench for jackpot_game with DIV_BASE=8, LEVELS=4, WIN_STEPS=6,
// N_LEDS=4 and SCORE_W=2. Expected output snapshots, each tagged with the
// cycle (negedges since reset release) at which it must hold, are queued
// ahead of time and popped and compared as the run reaches that cycle.
// -----------------------------------------------------------------------------
module tb_jackpot_game;

    logic       clk;
    logic       RESET;
    logic [3:0] SWITCHES;
    logic       MODE;
    logic [3:0] LEDS;
    logic [1:0] SCORE;
    logic [1:0] LEVEL;
    logic       WIN;

    typedef struct {
        int         t;
        string      tag;
        logic [3:0] leds;
        logic [1:0] score;
        logic [1:0] level;
        logic       win;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_tests;
    int   n_fail;

    jackpot_game #(
        .N_LEDS    (4),
        .DIV_BASE  (8),
        .LEVELS    (4),
        .WIN_STEPS (6),
        .SCORE_W   (2)
    ) dut (
        .CLOCK    (clk),
        .RESET    (RESET),
        .SWITCHES (SWITCHES),
        .MODE     (MODE),
        .LEDS     (LEDS),
        .SCORE    (SCORE),
        .LEVEL    (LEVEL),
        .WIN      (WIN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_to(input int t);
        while (cyc < t) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_now(input string tag, input logic [3:0] l, input logic [1:0] s,
                             input logic [1:0] lv, input logic w);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {LEDS, SCORE, LEVEL, WIN};
        exp = {l, s, lv, w};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed leds=%b score=%0d level=%0d win=%b, expected leds=%b score=%0d level=%0d win=%b",
                   tag, cyc, LEDS, SCORE, LEVEL, WIN, l, s, lv, w);
        end
    endtask

    task automatic expect_at(input int t, input string tag, input logic [3:0] l,
                             input logic [1:0] s, input logic [1:0] lv, input logic w);
        exp_t e;
        e.t = t; e.tag = tag; e.leds = l; e.score = s; e.level = lv; e.win = w;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step_to(e.t);
            check_now(e.tag, e.leds, e.score, e.level, e.win);
        end
    endtask

    task automatic reset_dut(input logic [3:0] sw);
        RESET    = 1'b0;
        SWITCHES = sw;
        MODE     = 1'b0;
        repeat (2) @(negedge clk);
        RESET = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        logic [3:0] pa [5];
        logic [3:0] pb [8];
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        RESET    = 1'b0;
        SWITCHES = 4'b0000;
        MODE     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_now("reset_state", 4'b1000, 2'd0, 2'd0, 1'b0);
        RESET = 1'b1;
        cyc   = 0;

        // Rotate walk: one change per 8 clocks
        pa = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        for (int k = 1; k < 5; k++) begin
            expect_at(8*k - 1, "rotate_hold", pa[k-1], 2'd0, 2'd0, 1'b0);
            expect_at(8*k,     "rotate_step", pa[k],   2'd0, 2'd0, 1'b0);
        end
        drain();

        // Ping-pong walk from 1000, end LEDs lit for one step only
        MODE = 1'b1;
        pb = '{4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
        for (int k = 0; k < 8; k++) begin
            expect_at(40 + 8*k, "pingpong_step", pb[k], 2'd0, 2'd0, 1'b0);
        end
        drain();

        // Hit on 0010: WIN four clocks later, blink at level-1 period of 4
        SWITCHES = 4'b0010;
        expect_at(99,  "hit_latency_pre", 4'b0010, 2'd0, 2'd0, 1'b0);
        expect_at(100, "hit_enter_win",   4'b1111, 2'd1, 2'd1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            expect_at(104 + 4*k, "win_blink", (k % 2 == 0) ? 4'b0000 : 4'b1111, 2'd1, 2'd1, 1'b1);
        end
        expect_at(124, "win_exit",        4'b1000, 2'd1, 2'd1, 1'b0);
        expect_at(128, "run_after_win",   4'b0100, 2'd1, 2'd1, 1'b0);
        expect_at(132, "held_no_retrig",  4'b0010, 2'd1, 2'd1, 1'b0);
        expect_at(136, "run_after_win",   4'b0001, 2'd1, 2'd1, 1'b0);
        expect_at(140, "run_after_win",   4'b0010, 2'd1, 2'd1, 1'b0);
        drain();

        // Asynchronous reset with a switch held high through release
        RESET    = 1'b0;
        SWITCHES = 4'b0001;
        MODE     = 1'b0;
        #1;
        check_now("async_reset", 4'b1000, 2'd0, 2'd0, 1'b0);
        repeat (2) @(negedge clk);
        RESET = 1'b1;
        cyc   = 0;
        expect_at(8,  "held_rotate",  4'b0100, 2'd0, 2'd0, 1'b0);
        expect_at(16, "held_rotate",  4'b0010, 2'd0, 2'd0, 1'b0);
        expect_at(28, "held_no_hit",  4'b0001, 2'd0, 2'd0, 1'b0);
        expect_at(32, "held_no_hit",  4'b1000, 2'd0, 2'd0, 1'b0);
        expect_at(48, "held_rotate",  4'b0010, 2'd0, 2'd0, 1'b0);
        drain();
        step_to(50);
        SWITCHES = 4'b0000;
        expect_at(56, "rearm_pos", 4'b0001, 2'd0, 2'd0, 1'b0);
        drain();
        SWITCHES = 4'b0001;
        expect_at(59, "rearm_pre", 4'b0001, 2'd0, 2'd0, 1'b0);
        expect_at(60, "rearm_hit", 4'b1111, 2'd1, 2'd1, 1'b1);
        drain();
        step_to(62);
        SWITCHES = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            expect_at(64 + 4*k, "win_blink", (k % 2 == 0) ? 4'b0000 : 4'b1111, 2'd1, 2'd1, 1'b1);
        end
        expect_at(84, "win_exit", 4'b1000, 2'd1, 2'd1, 1'b0);
        drain();

        // Hit landing on the same edge as a step: hit wins
        SWITCHES = 4'b1000;
        expect_at(87, "hit_step_pre",   4'b1000, 2'd1, 2'd1, 1'b0);
        expect_at(88, "hit_beats_step", 4'b1111, 2'd2, 2'd2, 1'b1);
        drain();
        step_to(90);
        SWITCHES = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            expect_at(90 + 2*k, "win_blink_l2", (k % 2 == 0) ? 4'b0000 : 4'b1111, 2'd2, 2'd2, 1'b1);
        end
        expect_at(100, "win_exit_l2", 4'b1000, 2'd2, 2'd2, 1'b0);
        expect_at(102, "run_l2",      4'b0100, 2'd2, 2'd2, 1'b0);
        drain();

        // Edge on an unlit LED
        step_to(103);
        SWITCHES = 4'b0100;
        expect_at(104, "run_l2", 4'b0010, 2'd2, 2'd2, 1'b0);
        expect_at(106, "run_l2", 4'b0001, 2'd2, 2'd2, 1'b0);
`ifdef JACKPOT_MISS_PENALTY_EN
        expect_at(107, "miss_penalty",    4'b0001, 2'd1, 2'd0, 1'b0);
        expect_at(108, "miss_slow_step",  4'b0001, 2'd1, 2'd0, 1'b0);
`else
        expect_at(107, "miss_ignored",    4'b0001, 2'd2, 2'd2, 1'b0);
        expect_at(108, "miss_step_kept",  4'b1000, 2'd2, 2'd2, 1'b0);
`endif
        drain();

        // Five hits from reset: level saturates at 3, score at 3
        reset_dut(4'b0000);
        step_to(1);
        SWITCHES = 4'b1000;
        expect_at(4, "sat_pre1", 4'b1000, 2'd0, 2'd0, 1'b0);
        expect_at(5, "sat_hit1", 4'b1111, 2'd1, 2'd1, 1'b1);
        drain();
        step_to(6);
        SWITCHES = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            expect_at(9 + 4*k, "sat_blink1", (k % 2 == 0) ? 4'b0000 : 4'b1111, 2'd1, 2'd1, 1'b1);
        end
        drain();
        step_to(28);
        SWITCHES = 4'b1000;
        expect_at(29, "sat_exit1", 4'b1000, 2'd1, 2'd1, 1'b0);
        expect_at(31, "sat_pre2",  4'b1000, 2'd1, 2'd1, 1'b0);
        expect_at(32, "sat_hit2",  4'b1111, 2'd2, 2'd2, 1'b1);
        drain();
        step_to(33);
        SWITCHES = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            expect_at(34 + 2*k, "sat_blink2", (k % 2 == 0) ? 4'b0000 : 4'b1111, 2'd2, 2'd2, 1'b1);
        end
        drain();
        step_to(41);
        SWITCHES = 4'b1000;
        expect_at(42, "sat_blink2", 4'b0000, 2'd2, 2'd2, 1'b1);
        expect_at(44, "sat_exit2",  4'b1000, 2'd2, 2'd2, 1'b0);
        expect_at(45, "sat_hit3",   4'b1111, 2'd3, 2'd3, 1'b1);
        drain();
        step_to(46);
        SWITCHES = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            expect_at(46 + k, "blink_period1", (k % 2 == 0) ? 4'b0000 : 4'b1111, 2'd3, 2'd3, 1'b1);
        end
        expect_at(51, "exit_period1", 4'b1000, 2'd3, 2'd3, 1'b0);
        expect_at(52, "run_period1",  4'b0100, 2'd3, 2'd3, 1'b0);
        expect_at(53, "run_period1",  4'b0010, 2'd3, 2'd3, 1'b0);
        expect_at(54, "run_period1",  4'b0001, 2'd3, 2'd3, 1'b0);
        expect_at(55, "run_period1",  4'b1000, 2'd3, 2'd3, 1'b0);
        drain();
        step_to(56);
        SWITCHES = 4'b1000;
        expect_at(59, "sat_pre4",       4'b1000, 2'd3, 2'd3, 1'b0);
        expect_at(60, "hit4_level_sat", 4'b1111, 2'd3, 2'd3, 1'b1);
        drain();
        step_to(61);
        SWITCHES = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            expect_at(61 + k, "blink_period1", (k % 2 == 0) ? 4'b0000 : 4'b1111, 2'd3, 2'd3, 1'b1);
        end
        expect_at(66, "exit_period1", 4'b1000, 2'd3, 2'd3, 1'b0);
        drain();
        step_to(67);
        SWITCHES = 4'b1000;
        expect_at(70, "sat_pre5",       4'b1000, 2'd3, 2'd3, 1'b0);
        expect_at(71, "hit5_score_sat", 4'b1111, 2'd3, 2'd3, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
